// File: rtl/l2_cache_control.sv
// L2 cache control FSM: sequences tag/data array strobes, writeback and fill
// bursts to physical memory, and keeps saturating hit/miss/writeback counters.
module l2_cache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             hit,
    input  logic             dirty_out,
    output logic             tag_load,
    output logic             valid_load,
    output logic             dirty_load,
    output logic             dirty_in,
    output logic [1:0]       writing,
    input  logic             perf_clear,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   first_cmp;
    logic   req;
    logic   is_write;
    logic   hit_inc;
    logic   miss_inc;
    logic   wb_inc;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            first_cmp <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req)
                first_cmp <= 1'b1;
            else if (state == FILL && pmem_resp)
                first_cmp <= 1'b0;
        end
    end

    // Strobes are suppressed while rst is high so no array is written during reset.
    always_comb begin
        next_state = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tag_load   = 1'b0;
        valid_load = 1'b0;
        dirty_load = 1'b0;
        dirty_in   = 1'b0;
        writing    = 2'b00;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req)
                        next_state = COMPARE;
                end
                COMPARE: begin
                    hit_inc  = first_cmp & hit;
                    miss_inc = first_cmp & ~hit;
                    if (hit) begin
                        mem_resp   = 1'b1;
                        next_state = IDLE;
                        if (is_write) begin
                            writing    = 2'b10;
                            dirty_load = 1'b1;
                            dirty_in   = 1'b1;
                        end
                    end else if (dirty_out) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        wb_inc     = 1'b1;
                        next_state = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        writing    = 2'b01;
                        tag_load   = 1'b1;
                        valid_load = 1'b1;
                        dirty_load = 1'b1;
                        dirty_in   = 1'b0;
                        next_state = COMPARE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // perf_clear wins over any increment landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_inc)
                hit_count <= sat_inc(hit_count);
            if (miss_inc)
                miss_count <= sat_inc(miss_count);
            if (wb_inc)
                wb_count <= sat_inc(wb_count);
        end
    end

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: transaction-level reference model driving randomized
// requests and checking every cycle's control outputs plus counter values.
module tb_l2_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, pmem_resp, hit, dirty_out, perf_clear;
    logic        mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in;
    logic [1:0]  writing;
    logic [31:0] hit_count, miss_count, wb_count;
    logic        d2_mem_resp, d2_pmem_read, d2_pmem_write, d2_tag_load, d2_valid_load;
    logic        d2_dirty_load, d2_dirty_in;
    logic [1:0]  d2_writing;
    logic [1:0]  d2_hit_count, d2_miss_count, d2_wb_count;

    int checks = 0;
    int errors = 0;
    int m_hit = 0, m_miss = 0, m_wb = 0;

    always #5 clk = ~clk;

    l2_cache_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit(hit), .dirty_out(dirty_out),
        .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_in(dirty_in), .writing(writing), .perf_clear(perf_clear),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    l2_cache_control #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(d2_mem_resp), .pmem_read(d2_pmem_read), .pmem_write(d2_pmem_write),
        .pmem_resp(pmem_resp), .hit(hit), .dirty_out(dirty_out),
        .tag_load(d2_tag_load), .valid_load(d2_valid_load), .dirty_load(d2_dirty_load),
        .dirty_in(d2_dirty_in), .writing(d2_writing), .perf_clear(perf_clear),
        .hit_count(d2_hit_count), .miss_count(d2_miss_count), .wb_count(d2_wb_count)
    );

    // Output vector: {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing}
    function automatic logic [8:0] obs_vec();
        return {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing};
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic run_txn(input bit rd, input bit wr, input bit hit0, input bit dirty,
                           input int dwb, input int dfill, input bit clr, input string name);
        int         n_cyc;
        int         fill_start;
        logic [8:0] exp;
        logic [8:0] obs;
        n_cyc      = hit0 ? 2 : (2 + (dirty ? dwb : 0) + dfill + 1);
        fill_start = 2 + (dirty ? dwb : 0);
        mem_read   = rd;
        mem_write  = wr;
        dirty_out  = dirty;
        for (int c = 0; c < n_cyc; c++) begin
            exp        = 9'b0;
            perf_clear = 1'b0;
            pmem_resp  = 1'b0;
            hit        = hit0;
            if (c == 0) begin
                pmem_resp = 1'($urandom_range(1, 0));
            end else if (c == 1) begin
                pmem_resp = 1'($urandom_range(1, 0));
                if (hit0) begin
                    perf_clear = clr;
                    exp[8]     = 1'b1;
                    if (wr) exp[3:0] = {1'b1, 1'b1, 2'b10};
                end
            end else if (c < fill_start) begin
                hit       = 1'($urandom_range(1, 0));
                exp[6]    = 1'b1;
                pmem_resp = (c == fill_start - 1);
            end else if (c < n_cyc - 1) begin
                hit    = 1'($urandom_range(1, 0));
                exp[7] = 1'b1;
                if (c == n_cyc - 2) begin
                    pmem_resp = 1'b1;
                    exp[5:0]  = {1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
                end
            end else begin
                hit       = 1'b1;
                pmem_resp = 1'($urandom_range(1, 0));
                exp[8]    = 1'b1;
                if (wr) exp[3:0] = {1'b1, 1'b1, 2'b10};
            end
            @(negedge clk);
            obs = obs_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %b expected %b", name, c, obs, exp);
            end
            @(posedge clk);
            #1;
        end
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        perf_clear = 1'b0;
        pmem_resp  = 1'b0;
        if (hit0) m_hit++; else m_miss++;
        if (!hit0 && dirty) m_wb++;
        if (clr && hit0) begin
            m_hit = 0; m_miss = 0; m_wb = 0;
        end
        checks++;
        if (hit_count !== 32'(m_hit) || miss_count !== 32'(m_miss) || wb_count !== 32'(m_wb)) begin
            errors++;
            $display("FAIL %s counts: got h=%0d m=%0d w=%0d expected h=%0d m=%0d w=%0d",
                     name, hit_count, miss_count, wb_count, m_hit, m_miss, m_wb);
        end
        checks++;
        if (d2_hit_count !== 2'(sat3(m_hit)) || d2_miss_count !== 2'(sat3(m_miss)) ||
            d2_wb_count !== 2'(sat3(m_wb))) begin
            errors++;
            $display("FAIL %s sat counts: got h=%0d m=%0d w=%0d expected h=%0d m=%0d w=%0d",
                     name, d2_hit_count, d2_miss_count, d2_wb_count,
                     sat3(m_hit), sat3(m_miss), sat3(m_wb));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit = 1'b0; dirty_out = 1'b0; perf_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 9'b0 || hit_count !== 32'd0 || miss_count !== 32'd0 || wb_count !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs %b counts %0d/%0d/%0d expected all zero",
                         i, obs_vec(), hit_count, miss_count, wb_count);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_fill();
        mem_read = 1'b1; hit = 1'b0; dirty_out = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill_pre: pmem_read got %b expected 1", pmem_read);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; mem_read = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 9'b0 || miss_count !== 32'd0) begin
                errors++;
                $display("FAIL mid_fill_reset cycle %0d: outputs %b miss %0d expected zero",
                         i, obs_vec(), miss_count);
            end
            @(posedge clk);
            #1;
        end
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0, "post_reset_hit");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++)
            run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0, "sat_hit");
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1, "clear_with_hit");
    endtask

    task automatic test_random(input int n, input bit b2b);
        bit rd, wr;
        int gap;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(2, 0))
                0: begin rd = 1'b1; wr = 1'b0; end
                1: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            run_txn(rd, wr, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    $urandom_range(6, 1), $urandom_range(6, 1), 1'b0, b2b ? "back_to_back" : "random");
            gap = b2b ? 0 : $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                pmem_resp = 1'($urandom_range(1, 0));
                hit       = 1'($urandom_range(1, 0));
                @(negedge clk);
                checks++;
                if (obs_vec() !== 9'b0) begin
                    errors++;
                    $display("FAIL idle_gap: outputs got %b expected 0", obs_vec());
                end
                @(posedge clk);
                #1;
            end
            pmem_resp = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0, "read_hit");
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0, "write_hit");
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 3, 5, 1'b0, "clean_read_miss");
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 4, 3, 1'b0, "dirty_write_miss");
        test_random(30, 1'b0);
        test_random(10, 1'b1);
        test_reset_mid_fill();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
Control FSM that sequences the L2 cache datapath (tag/valid/dirty arrays, data array, pmem address mux) between the L1/arbiter-side request port and physical memory. Decodes requests, drives the datapath load strobes and `writing` select, runs the writeback and fill bursts, and keeps saturating hit/miss/writeback performance counters. Sits beside the datapath inside the L2 top level. It shares `hit`/`dirty_out`/`tag_load`/`valid_load`/`dirty_load`/`dirty_in`/`writing` with that datapath.

Parameters:
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
mem_read  input  1  upstream read request, held until mem_resp.
mem_write  input  1  upstream write request (full 256-bit line, byte-enabled), held until mem_resp.
mem_resp  output  1  one-cycle completion pulse to upstream.
pmem_read  output  1  line fill request to physical memory, held until pmem_resp.
pmem_write  output  1  line writeback request to physical memory, held until pmem_resp.
pmem_resp  input  1  physical memory completion pulse.
hit  input  1  datapath tag match AND valid for current mem_address.
dirty_out  input  1  dirty bit of the line currently indexed.
tag_load  output  1  load tag array this cycle.
valid_load  output  1  load valid bit (set to 1) this cycle.
dirty_load  output  1  load dirty bit with dirty_in this cycle.
dirty_in  output  1  value written to the dirty bit.
writing  output  2  data array write select: 2'b00 no write, 2'b01 write pmem_rdata (fill), 2'b10 write mem_wdata under mem_byte_enable (CPU write).
perf_clear  input  1  synchronous clear of all counters.
hit_count  output  CNT_W  requests completed as hits on first COMPARE.
miss_count  output  CNT_W  requests that missed on first COMPARE.
wb_count  output  CNT_W  writebacks completed.

Behaviour:
- All outputs are Moore/Mealy combinational from state plus `hit`, `dirty_out`, and `pmem_resp`. Default value of every control output is 0, with `writing` = 2'b00.
- Reset: state goes to IDLE, all counters go to 0, and all control outputs are 0 in the cycle after rst. If reset is asserted mid-WRITEBACK or mid-FILL, the pmem request drops immediately. Physical memory must tolerate the abandoned request. No datapath array is written during reset.
- Request: req = mem_read | mem_write. If both are asserted, the request is treated as a write.
- IDLE: if req, go to COMPARE. Otherwise stay in IDLE.
- COMPARE, hit, read: mem_resp = 1, then go to IDLE.
- COMPARE, hit, write: writing = 2'b10, dirty_load = 1, dirty_in = 1, mem_resp = 1, then go to IDLE.
- COMPARE, miss: if dirty_out go to WRITEBACK, else go to FILL.
- First-COMPARE flag: a register is set on entry from IDLE and cleared on entry from FILL. It decides whether a COMPARE outcome counts as a hit or a miss. The re-COMPARE after a fill is never counted.
- WRITEBACK: pmem_write = 1 (datapath supplies the victim address and data). On pmem_resp, wb_count increments and the next state is FILL. No array load occurs in this state.
- FILL: pmem_read = 1. On pmem_resp: writing = 2'b01, tag_load = 1, valid_load = 1, dirty_load = 1, dirty_in = 0, then go to COMPARE. The re-COMPARE is then guaranteed to hit.
- Latency, measured from the first cycle req is high in IDLE (cycle N):
  - Hit: mem_resp in N+1.
  - Clean miss: mem_resp one cycle after the FILL pmem_resp cycle.
  - Dirty miss: additionally includes the full writeback handshake.
- mem_resp is never asserted for two consecutive cycles. After mem_resp the FSM returns to IDLE, so a request still held high in the next cycle starts a new transaction.
- pmem_read and pmem_write are never asserted together, and each stays high continuously until pmem_resp.
- A pmem_resp arriving in IDLE or COMPARE is ignored.
- Counters saturate at all-ones and do not wrap.
- perf_clear takes priority over an increment in the same cycle, and it does not affect the FSM.

Test Plan:
1. Reset then IDLE: hold rst 2 cycles, then idle 3 cycles -> all control outputs are 0, all counts are 0, and no mem_resp.
2. Read hit: mem_read=1 with hit=1 -> mem_resp exactly at cycle N+1, writing=00, no loads; hit_count=1.
3. Write hit: mem_write=1 with hit=1 -> at cycle N+1, writing=10, dirty_load=1, dirty_in=1, mem_resp=1; miss_count=0.
4. Clean read miss: hit=0, dirty_out=0, pmem_resp after 5 cycles -> pmem_read high for 5 cycles, then a fill strobe cycle (writing=01, tag/valid/dirty_load=1, dirty_in=0), then mem_resp the next cycle with hit=1; miss_count=1, hit_count=0.
5. Dirty write miss: dirty_out=1 -> pmem_write until pmem_resp, then pmem_read until pmem_resp, then COMPARE with a write hit (writing=10) and mem_resp; wb_count=1. Also check that pmem_read and pmem_write never overlap.
6. Reset mid-FILL plus saturation: assert rst while pmem_read=1 -> pmem_read=0 the next cycle and state is IDLE. Separately, with CNT_W=2, run 5 hits -> hit_count=3. Then pulse perf_clear together with a hit -> hit_count=0.
